// File: rtl/round_robin_dispatcher_pkg.sv
// Shared definitions for the round-robin fan-out (dispatcher) and fan-in
// (arbiter) blocks. The defaults live here so both ends of the datapath
// agree on port count and payload width.
//
// Contents:
//   DEF_NUM_PORT  default number of fan-out/fan-in ports
//   DEF_DATA_W    default payload width in bits
//   DEF_CNT_W     default width of the dispatched-word counter
//   clog2()       ceiling log2 helper for index widths
package round_robin_dispatcher_pkg;

  localparam int unsigned DEF_NUM_PORT = 4;
  localparam int unsigned DEF_DATA_W   = 64;
  localparam int unsigned DEF_CNT_W    = 16;

  // Ceiling log2; returns 1 for inputs of 0 or 1 so the result is always
  // usable as a vector width.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_port_select.sv
// Cyclic first-free search for the round-robin dispatcher.
//
// Ports:
//   free     in   NUM_PORT  one bit per port, 1 = port can take a word
//   pointer  in   NUM_PORT  one-hot start position of the search
//   enable   in   1         1 = cyclic search; 0 = only port 0 is eligible
//   sel      out  NUM_PORT  one-hot chosen port, all-zero if none
module rr_port_select
  import round_robin_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_PORT = DEF_NUM_PORT
) (
  input  logic [NUM_PORT-1:0] free,
  input  logic [NUM_PORT-1:0] pointer,
  input  logic                enable,
  output logic [NUM_PORT-1:0] sel
);

  logic [NUM_PORT-1:0] mask;
  logic [NUM_PORT-1:0] masked;
  logic [NUM_PORT-1:0] masked_sel;
  logic [NUM_PORT-1:0] unmasked_sel;

  // Two lowest-set-bit searches: one restricted to ports at or above the
  // pointer, one over all ports. The masked result wins when non-empty,
  // which gives the wrap-around scan without a variable rotate.
  always_comb begin
    mask         = ~(pointer - NUM_PORT'(1));
    masked       = free & mask;
    masked_sel   = masked & (~masked + NUM_PORT'(1));
    unmasked_sel = free & (~free + NUM_PORT'(1));

    sel = '0;
    if (!enable) begin
      sel[0] = free[0];
    end else if (|masked) begin
      sel = masked_sel;
    end else begin
      sel = unmasked_sel;
    end
  end

endmodule

// File: rtl/round_robin_dispatcher.sv
// Round-robin dispatcher: fans one valid/ready stream out to NUM_PORT
// registered output ports, one word per accept, skipping busy ports.
//
// Ports:
//   clk              in   1                  clock
//   rst              in   1                  async active-high reset
//   dispatch_enable  in   1                  1 = round-robin, 0 = port 0 only
//   in_valid         in   1                  input word valid
//   in_ready         out  1                  word can be accepted this cycle
//   in_data          in   DATA_W             input payload
//   out_valid        out  NUM_PORT           per-port valid (registered)
//   out_ready        in   NUM_PORT           per-port downstream ready
//   out_data         out  NUM_PORT*DATA_W    per-port payload, port i at
//                                            [i*DATA_W +: DATA_W]
//   last_port        out  NUM_PORT           one-hot port of latest word
//   disp_cnt         out  CNT_W              accepted-word count, wraps
module round_robin_dispatcher
  import round_robin_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_PORT = DEF_NUM_PORT,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dispatch_enable,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  output logic [NUM_PORT-1:0]          out_valid,
  input  logic [NUM_PORT-1:0]          out_ready,
  output logic [NUM_PORT*DATA_W-1:0]   out_data,
  output logic [NUM_PORT-1:0]          last_port,
  output logic [CNT_W-1:0]             disp_cnt
);

  logic [NUM_PORT-1:0] pointer;
  logic [NUM_PORT-1:0] free;
  logic [NUM_PORT-1:0] sel;
  logic                accept;

  // A draining port counts as free so it can be reloaded back-to-back.
  assign free = ~out_valid | out_ready;

  rr_port_select #(
    .NUM_PORT (NUM_PORT)
  ) u_select (
    .free    (free),
    .pointer (pointer),
    .enable  (dispatch_enable),
    .sel     (sel)
  );

  // Gated by rst: during reset the port registers are empty and would
  // otherwise advertise ready.
  assign in_ready = (|sel) & ~rst;
  assign accept   = in_valid & in_ready;

  // The pointer only advances in round-robin mode; forced-to-port-0
  // traffic leaves it where the rotation left off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pointer <= NUM_PORT'(1);
    end else if (accept && dispatch_enable) begin
      pointer <= {sel[NUM_PORT-2:0], sel[NUM_PORT-1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PORT; i++) begin
        if (accept && sel[i]) begin
          out_valid[i]                 <= 1'b1;
          out_data[i*DATA_W +: DATA_W] <= in_data;
        end else if (out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_port <= '0;
      disp_cnt  <= '0;
    end else if (accept) begin
      last_port <= sel;
      disp_cnt  <= disp_cnt + CNT_W'(1);
    end
  end

endmodule
